// File: rtl/ifu_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues single-word reads and hands
// each fetched word to the IDU with a level Fetch_ready / IDU_ready handshake.
module ifu_fetch_sequencer #(
  parameter logic [31:0]  RESET_PC       = 32'h0000_0000,
  parameter int unsigned  TIMEOUT_CYCLES = 15
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        IDU_ready,
  input  logic [31:0] pc_increment,
  input  logic        cu_advance,
  input  logic        cu_redirect_valid,
  input  logic [31:0] cu_redirect_pc,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_WAIT_CU,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   incr_q, incr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rd_en_q, rd_en_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [XLEN-1:0]   pc_next;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign pc_next = cu_redirect_valid ? cu_redirect_pc : (pc_q + incr_q);

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    incr_d  = incr_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    rd_en_d = 1'b0;
    fault_d = fault_q;
    cause_d = cause_q;

    case (state_q)
      S_IDLE: begin
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = CAUSE_MISALIGN;
        end else begin
          state_d = S_REQ;
          rd_en_d = 1'b1;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      // A response in the expiry cycle still beats the timeout.
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_HOLD;
          instr_d = mem_rdata;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
          end
        end
      end

      S_HOLD: begin
        if (IDU_ready) begin
          state_d = S_WAIT_CU;
          incr_d  = pc_increment;
          ready_d = 1'b0;
        end
      end

      // A misaligned target is still committed to pc so the CU can see it.
      S_WAIT_CU: begin
        if (cu_advance) begin
          pc_d = pc_next;
          if (pc_next[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_REQ;
            rd_en_d = 1'b1;
          end
        end
      end

      S_FAULT: begin
        ready_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      incr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rd_en_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      incr_q  <= incr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rd_en_q <= rd_en_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign Fetch_ready = ready_q;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_ifu_fetch_sequencer.sv
// Bench for ifu_fetch_sequencer: the bench plays memory, IDU and CU, and tracks
// the expected PC stream as a plain sequence of next-PC computations.
module tb_ifu_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TO       = 15;

  logic        soc_clk;
  logic        reset;
  logic        IDU_ready;
  logic [31:0] pc_increment;
  logic        cu_advance;
  logic        cu_redirect_valid;
  logic [31:0] cu_redirect_pc;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic [31:0] pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  ifu_fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
    .soc_clk           (soc_clk),
    .reset             (reset),
    .IDU_ready         (IDU_ready),
    .pc_increment      (pc_increment),
    .cu_advance        (cu_advance),
    .cu_redirect_valid (cu_redirect_valid),
    .cu_redirect_pc    (cu_redirect_pc),
    .mem_rdata         (mem_rdata),
    .mem_rvalid        (mem_rvalid),
    .mem_rd_en         (mem_rd_en),
    .mem_addr          (mem_addr),
    .instruction       (instruction),
    .Fetch_ready       (Fetch_ready),
    .pc                (pc),
    .fetch_fault       (fetch_fault),
    .fault_cause       (fault_cause)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int          checks;
  int          failures;
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic clear_inputs();
    IDU_ready         = 1'b0;
    pc_increment      = '0;
    cu_advance        = 1'b0;
    cu_redirect_valid = 1'b0;
    cu_redirect_pc    = '0;
    mem_rdata         = '0;
    mem_rvalid        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    check("rst_ready", 32'(Fetch_ready), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_addr", mem_addr, RESET_PC);
    check("rst_instr", instruction, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    reset  = 1'b0;
    exp_pc = RESET_PC;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ok = (mem_rd_en === 1'b1);
    check("req_seen", 32'(ok), 32'd1);
  endtask

  // One complete instruction: request, response after lat cycles, hold for
  // hold cycles, IDU accept, CU resolve after cu_dly cycles.
  task automatic fetch(input int lat, input int hold, input logic [31:0] incr,
                       input bit redir, input logic [31:0] rpc, input int cu_dly,
                       input bit stray);
    bit          ok;
    int          high;
    logic [31:0] word;
    wait_req(ok);
    if (!ok) return;
    check("req_addr", mem_addr, exp_pc);
    check("req_pc", pc, exp_pc);
    tick();
    check("rd_en_pulse", 32'(mem_rd_en), 32'd0);
    for (int i = 1; i < lat; i++) begin
      tick();
      check("wait_ready", 32'(Fetch_ready), 32'd0);
    end
    word       = mem_word(exp_pc);
    mem_rdata  = word;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    check("ready_rise", 32'(Fetch_ready), 32'd1);
    check("instr", instruction, word);
    high = 1;
    for (int i = 1; i < hold; i++) begin
      pc_increment = $urandom;
      if (stray) begin
        mem_rvalid        = 1'b1;
        mem_rdata         = $urandom;
        cu_advance        = 1'b1;
        cu_redirect_valid = 1'b1;
        cu_redirect_pc    = $urandom & 32'hFFFF_FFFC;
      end
      tick();
      mem_rvalid        = 1'b0;
      cu_advance        = 1'b0;
      cu_redirect_valid = 1'b0;
      if (Fetch_ready === 1'b1) high++;
      check("hold_instr", instruction, word);
      check("hold_pc", pc, exp_pc);
      check("hold_rd_en", 32'(mem_rd_en), 32'd0);
    end
    IDU_ready    = 1'b1;
    pc_increment = incr;
    tick();
    IDU_ready    = 1'b0;
    pc_increment = $urandom;
    check("ready_cycles", 32'(high), 32'(hold));
    check("ready_fall", 32'(Fetch_ready), 32'd0);
    for (int i = 0; i < cu_dly; i++) begin
      IDU_ready         = 1'b1;
      pc_increment      = $urandom;
      cu_redirect_valid = 1'b1;
      cu_redirect_pc    = $urandom & 32'hFFFF_FFFC;
      tick();
      IDU_ready         = 1'b0;
      cu_redirect_valid = 1'b0;
      check("wcu_ready", 32'(Fetch_ready), 32'd0);
      check("wcu_rd_en", 32'(mem_rd_en), 32'd0);
      check("wcu_pc", pc, exp_pc);
    end
    cu_advance        = 1'b1;
    cu_redirect_valid = redir;
    cu_redirect_pc    = rpc;
    tick();
    cu_advance        = 1'b0;
    cu_redirect_valid = 1'b0;
    exp_pc = redir ? rpc : exp_pc + incr;
    check("next_pc", pc, exp_pc);
    if (exp_pc[1:0] != 2'b00) begin
      check("mis_fault", 32'(fetch_fault), 32'd1);
      check("mis_cause", 32'(fault_cause), 32'd1);
      check("mis_rd_en", 32'(mem_rd_en), 32'd0);
    end else begin
      check("next_rd_en", 32'(mem_rd_en), 32'd1);
      check("next_addr", mem_addr, exp_pc);
      check("next_fault", 32'(fetch_fault), 32'd0);
    end
  endtask

  // Fault must be sticky against every non-reset input.
  task automatic fault_sticky(input logic [1:0] cause, input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid        = 1'($urandom_range(0, 1));
      mem_rdata         = $urandom;
      IDU_ready         = 1'($urandom_range(0, 1));
      cu_advance        = 1'($urandom_range(0, 1));
      cu_redirect_valid = 1'($urandom_range(0, 1));
      cu_redirect_pc    = $urandom & 32'hFFFF_FFFC;
      tick();
      check("flt_fault", 32'(fetch_fault), 32'd1);
      check("flt_cause", 32'(fault_cause), 32'(cause));
      check("flt_rd_en", 32'(mem_rd_en), 32'd0);
      check("flt_ready", 32'(Fetch_ready), 32'd0);
      check("flt_pc", pc, exp_pc);
    end
    clear_inputs();
  endtask

  // Withhold the response for TO-1 WAIT cycles, then either answer or expire.
  task automatic timeout_run(input bit answer_last);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_nofault", 32'(fetch_fault), 32'd0);
    end
    if (answer_last) begin
      mem_rdata  = mem_word(exp_pc);
      mem_rvalid = 1'b1;
    end
    tick();
    mem_rvalid = 1'b0;
    if (answer_last) begin
      check("to_last_ready", 32'(Fetch_ready), 32'd1);
      check("to_last_fault", 32'(fetch_fault), 32'd0);
      check("to_last_instr", instruction, mem_word(exp_pc));
    end else begin
      check("to_fault", 32'(fetch_fault), 32'd1);
      check("to_cause", 32'(fault_cause), 32'd2);
      check("to_ready", 32'(Fetch_ready), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int d;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();

    // Basic flow and first-fetch latency.
    do_reset();
    tick();
    check("lat_req_c1", 32'(mem_rd_en), 32'd1);
    check("lat_addr_c1", mem_addr, RESET_PC);
    fetch(1, 4, 32'd4, 1'b0, 32'h0, 1, 1'b0);
    check("pc_after_first", pc, 32'h4);
    fetch(1, 4, 32'd4, 1'b0, 32'h0, 2, 1'b0);

    // Backward increment and redirect overriding the increment.
    fetch(1, 1, $urandom, 1'b1, 32'h10, 0, 1'b0);
    fetch(2, 2, 32'hFFFF_FFF8, 1'b0, 32'h0, 1, 1'b0);
    check("neg_incr_pc", pc, 32'h8);
    fetch(3, 2, 32'h40, 1'b1, 32'h100, 0, 1'b1);
    check("redir_pc", pc, 32'h100);

    // Wrap-around with stray inputs during HOLD.
    fetch(1, 1, 32'h0, 1'b1, 32'hFFFF_FFFC, 0, 1'b0);
    fetch(2, 4, 32'd4, 1'b0, 32'h0, 1, 1'b1);
    check("wrap_pc", pc, 32'h0);

    // Randomized instruction stream.
    for (int k = 0; k < 25; k++) begin
      d = int'($urandom_range(0, 64)) - 32;
      fetch(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)), 32'(d * 4),
            1'($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC,
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Misaligned redirect target.
    fetch(1, 2, 32'd4, 1'b1, 32'h102, 1, 1'b0);
    check("mis_redir_pc", pc, 32'h102);
    fault_sticky(2'b01, 8);

    // Misaligned increment.
    do_reset();
    fetch(1, 1, 32'd2, 1'b0, 32'h0, 0, 1'b0);
    fault_sticky(2'b01, 4);

    // Memory timeout, then response in the expiry cycle.
    do_reset();
    timeout_run(1'b0);
    fault_sticky(2'b10, 6);
    do_reset();
    timeout_run(1'b1);

    // Reset mid-HOLD.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = RESET_PC;
    check("rh_ready", 32'(Fetch_ready), 32'd0);
    check("rh_pc", pc, RESET_PC);
    check("rh_instr", instruction, 32'h0);
    check("rh_fault", 32'(fetch_fault), 32'd0);

    // Reset mid-WAIT with a late response that must be discarded.
    wait_req(ok);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ready", 32'(Fetch_ready), 32'd0);
    check("rw_pc", pc, RESET_PC);
    mem_rdata  = 32'hDEAD_BEEF;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check("rw_late_ready", 32'(Fetch_ready), 32'd0);
    check("rw_late_instr", instruction, 32'h0);
    check("rw_fresh_req", 32'(mem_rd_en), 32'd1);
    fetch(1, 2, 32'd8, 1'b0, 32'h0, 1, 1'b0);
    check("rw_next_pc", pc, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_sequencer.md
Name: ifu_fetch_sequencer

Overview:
- Instruction fetch unit feeding the IDU.
- Owns the architectural PC and issues single-word read requests to instruction memory.
- Latches the returned word and presents it on `instruction` with a level `Fetch_ready` handshake, holding it until the IDU answers with `IDU_ready`.
- Computes the next PC from the IDU-supplied `pc_increment`, or from a CU redirect, once the CU signals `cu_advance`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, maximum cycles spent in WAIT before a fetch fault is raised (range 1..255).

Ports:
- soc_clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- IDU_ready  input  1  IDU decode-complete; level, sampled only in HOLD.
- pc_increment  input  32  signed PC offset from the IDU; valid while IDU_ready=1.
- cu_advance  input  1  one-cycle pulse from the CU: the current instruction is resolved, fetch the next one.
- cu_redirect_valid  input  1  qualifies cu_redirect_pc; meaningful only together with cu_advance.
- cu_redirect_pc  input  32  absolute next PC (JALR/taken branch).
- mem_rdata  input  32  instruction memory read data.
- mem_rvalid  input  1  mem_rdata valid this cycle.
- mem_rd_en  output  1  one-cycle read request.
- mem_addr  output  32  read address; equals pc.
- instruction  output  32  fetched word presented to the IDU.
- Fetch_ready  output  1  instruction is valid for the IDU.
- pc  output  32  PC of the instruction currently presented (used by CU for AUIPC/JAL).
- fetch_fault  output  1  sticky fault flag.
- fault_cause  output  2  00 none, 01 misaligned PC, 10 memory timeout.

Behaviour:
- Reset (synchronous, highest priority, any state):
  - State IDLE; pc=RESET_PC; mem_addr=RESET_PC; instruction=32'h0000_0000.
  - Fetch_ready=0; mem_rd_en=0; fetch_fault=0; fault_cause=00.
  - Timeout counter=0; latched increment=0.
- State machine: IDLE, REQ, WAIT, HOLD, WAIT_CU, FAULT.
- IDLE: next cycle go to REQ. If pc[1:0]!=0 go to FAULT with cause 01 instead.
- REQ:
  - mem_rd_en=1 for exactly this cycle, mem_addr=pc.
  - mem_rvalid is ignored in this cycle, so memory latency is at least 1.
  - Go to WAIT; clear the timeout counter.
- WAIT:
  - On mem_rvalid=1: instruction<=mem_rdata, Fetch_ready<=1, go to HOLD.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES without rvalid, go to FAULT with cause 10.
  - mem_rvalid in the expiry cycle wins over the timeout.
- HOLD:
  - Fetch_ready=1; instruction and pc are held stable.
  - On the first cycle with IDU_ready=1: latch pc_increment, Fetch_ready<=0, go to WAIT_CU.
  - IDU_ready=0: remain, with no timeout.
- WAIT_CU:
  - Fetch_ready=0.
  - On cu_advance=1: pc<=cu_redirect_valid ? cu_redirect_pc : pc + latched increment, using 32-bit modular arithmetic (wrap-around allowed).
  - Next state is REQ, or FAULT with cause 01 if the new pc[1:0]!=0; pc still updates to the offending value.
- FAULT: fetch_fault=1, fault_cause held, Fetch_ready=0, mem_rd_en=0. Exit only via reset.
- Ignored events:
  - mem_rvalid outside WAIT.
  - cu_advance outside WAIT_CU.
  - IDU_ready outside HOLD.
  - cu_redirect_valid without cu_advance.
- Fetch_ready stays high for at least one cycle per instruction. It is never reasserted without a new REQ/WAIT sequence.
- Latency with 1-cycle memory: reset release → REQ at cycle 1, WAIT at cycle 2, rvalid at cycle 2, Fetch_ready=1 from cycle 3.
- Reset during HOLD or WAIT drops Fetch_ready in the same clock edge. An outstanding memory response arriving later is discarded.

Test Plan:
1. Reset with RESET_PC=0, memory returns 32'h0000_0013 one cycle after request, IDU_ready after 4 cycles, cu_advance with pc_increment=4 → second mem_addr=0x4, Fetch_ready high 4 cycles per instruction, pc=0x4.
2. JAL-style: pc_increment=32'hFFFF_FFF8 at pc=0x10 → next mem_addr=0x8. cu_advance with cu_redirect_valid=1, cu_redirect_pc=0x100 → mem_addr=0x100 regardless of increment.
3. Misaligned: cu_redirect_pc=0x102 → pc=0x102, fetch_fault=1, fault_cause=01, no further mem_rd_en; only reset clears it.
4. Timeout: mem_rvalid withheld with TIMEOUT_CYCLES=15 → fault_cause=10 after 15 WAIT cycles. A variant with rvalid on exactly the 15th cycle produces no fault and a normal HOLD.
5. Wrap and spurious inputs: pc=0xFFFF_FFFC, increment 4 → pc=0x0. Stray mem_rvalid in HOLD and cu_advance in HOLD cause no state or output change.
6. Reset asserted mid-HOLD and mid-WAIT → next cycle Fetch_ready=0, pc=RESET_PC, instruction=0. A late mem_rvalid is ignored and a fresh REQ follows.
